// File: rtl/fighter_anim_ctrl.sv
// fighter_anim_ctrl: per-fighter animation sequencer and
// sprite ROM address generator (stand / punch / hit).
module fighter_anim_ctrl #(
  parameter int SPRITE_W     = 48,
  parameter int SPRITE_H     = 80,
  parameter int IDLE_FRAMES  = 4,
  parameter int PUNCH_FRAMES = 4,
  parameter int HIT_FRAMES   = 2,
  parameter int HOLD_TICKS   = 6
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        punch_req,
  input  logic        hit_req,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        facing_left,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  output logic [13:0] rom_address,
  output logic [1:0]  anim_sel,
  output logic        sprite_on,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_TICKS - 1);

  localparam logic [1:0] IDLE_LAST  = 2'(IDLE_FRAMES - 1);
  localparam logic [1:0] PUNCH_LAST = 2'(PUNCH_FRAMES - 1);
  localparam logic [1:0] HIT_LAST   = 2'(HIT_FRAMES - 1);

  localparam logic [13:0] FRAME_SZ =
    14'(SPRITE_W * SPRITE_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PUNCH = 2'd1,
    S_HIT   = 2'd2
  } state_t;

  state_t          r_state;
  logic [1:0]      r_frame;
  logic [HW-1:0]   r_hold;
  logic            r_pend_hit;
  logic            r_pend_punch;
  logic [1:0]      r_anim_sel;
  logic            r_busy;
  logic [13:0]     r_rom_address;
  logic            r_sprite_on;

  // A request in the same cycle as the tick counts
  // as already pending.
  logic w_hit;
  logic w_punch;

  assign w_hit   = r_pend_hit | hit_req;
  assign w_punch = r_pend_punch |
                   (punch_req & (r_state == S_IDLE));

  // Animation state, frame/hold counters, request
  // latches and registered state outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_frame      <= '0;
      r_hold       <= '0;
      r_pend_hit   <= 1'b0;
      r_pend_punch <= 1'b0;
      r_anim_sel   <= 2'd0;
      r_busy       <= 1'b0;
    end else if (frame_tick) begin
      r_pend_hit   <= 1'b0;
      r_pend_punch <= 1'b0;
      if (w_hit) begin
        r_state    <= S_HIT;
        r_frame    <= '0;
        r_hold     <= '0;
        r_anim_sel <= 2'd2;
        r_busy     <= 1'b1;
      end else if (r_state == S_IDLE && w_punch) begin
        r_state    <= S_PUNCH;
        r_frame    <= '0;
        r_hold     <= '0;
        r_anim_sel <= 2'd1;
        r_busy     <= 1'b1;
      end else if (r_hold < HOLD_LAST) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
        unique case (r_state)
          S_IDLE: begin
            if (r_frame == IDLE_LAST)
              r_frame <= '0;
            else
              r_frame <= r_frame + 1'b1;
          end
          S_PUNCH: begin
            if (r_frame == PUNCH_LAST) begin
              r_state    <= S_IDLE;
              r_frame    <= '0;
              r_anim_sel <= 2'd0;
              r_busy     <= 1'b0;
            end else begin
              r_frame <= r_frame + 1'b1;
            end
          end
          S_HIT: begin
            if (r_frame == HIT_LAST) begin
              r_state    <= S_IDLE;
              r_frame    <= '0;
              r_anim_sel <= 2'd0;
              r_busy     <= 1'b0;
            end else begin
              r_frame <= r_frame + 1'b1;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_anim_sel <= 2'd0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end else begin
      if (hit_req)
        r_pend_hit <= 1'b1;
      if (punch_req && r_state == S_IDLE)
        r_pend_punch <= 1'b1;
    end
  end

  // Sprite-relative coordinates; negative offsets wrap
  // large and so fall outside the box.
  logic [9:0]  w_rel_x;
  logic [9:0]  w_rel_y;
  logic [9:0]  w_col;
  logic        w_inside;
  logic [13:0] w_addr;

  assign w_rel_x  = draw_x - pos_x;
  assign w_rel_y  = draw_y - pos_y;
  assign w_inside = (w_rel_x < 10'(SPRITE_W)) &&
                    (w_rel_y < 10'(SPRITE_H));
  assign w_col    = facing_left ?
                    (10'(SPRITE_W - 1) - w_rel_x) :
                    w_rel_x;
  assign w_addr   = (14'(r_frame) * FRAME_SZ) +
                    (14'(w_rel_y) * 14'(SPRITE_W)) +
                    14'(w_col);

  // Registered ROM address and coverage flag, one
  // pixel clock behind draw_x/draw_y.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rom_address <= '0;
      r_sprite_on   <= 1'b0;
    end else if (w_inside) begin
      r_rom_address <= w_addr;
      r_sprite_on   <= 1'b1;
    end else begin
      r_rom_address <= '0;
      r_sprite_on   <= 1'b0;
    end
  end

  assign rom_address = r_rom_address;
  assign sprite_on   = r_sprite_on;
  assign anim_sel    = r_anim_sel;
  assign busy        = r_busy;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// tb_fighter_anim_ctrl: directed checks of animation
// sequencing and sprite address generation.
module tb_fighter_anim_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        punch_req;
  logic        hit_req;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        facing_left;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [13:0] rom_address;
  logic [1:0]  anim_sel;
  logic        sprite_on;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam int FSZ = 48 * 80;

  always #5 vga_clk = ~vga_clk;

  fighter_anim_ctrl dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .punch_req   (punch_req),
    .hit_req     (hit_req),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .facing_left (facing_left),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .rom_address (rom_address),
    .anim_sel    (anim_sel),
    .sprite_on   (sprite_on),
    .busy        (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++)
      @(negedge vga_clk);
  endtask

  // one tick pulse, then let the address path catch up
  task automatic tick();
    @(negedge vga_clk);
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    reset = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;
  endtask

  task automatic punch();
    @(negedge vga_clk);
    punch_req = 1'b1;
    @(negedge vga_clk);
    punch_req = 1'b0;
  endtask

  task automatic hit();
    @(negedge vga_clk);
    hit_req = 1'b1;
    @(negedge vga_clk);
    hit_req = 1'b0;
  endtask

  // draw == pos, facing right: address = frame * FSZ
  task automatic chk_st(input string tag,
                        input int a, input int f);
    check({tag, "_anim"}, 32'(anim_sel), 32'(a));
    check({tag, "_busy"}, 32'(busy), 32'(a != 0));
    check({tag, "_frame"}, 32'(rom_address),
          32'(f * FSZ));
  endtask

  initial begin
    reset       = 1'b1;
    frame_tick  = 1'b0;
    punch_req   = 1'b0;
    hit_req     = 1'b0;
    facing_left = 1'b0;
    pos_x       = 10'd100;
    pos_y       = 10'd50;
    draw_x      = 10'd500;
    draw_y      = 10'd400;
    cyc(3);
    reset = 1'b0;
    check("rst_anim", 32'(anim_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_on", 32'(sprite_on), 0);
    check("rst_addr", 32'(rom_address), 0);

    // address path at frame 0
    draw_x = 10'd110; draw_y = 10'd60;
    cyc(1);
    check("addr_r", 32'(rom_address), 490);
    check("on_r", 32'(sprite_on), 1);
    facing_left = 1'b1;
    cyc(1);
    check("addr_l", 32'(rom_address), 517);
    facing_left = 1'b0;
    draw_x = 10'd99;
    cyc(1);
    check("left_on", 32'(sprite_on), 0);
    check("left_addr", 32'(rom_address), 0);
    draw_x = 10'd147; draw_y = 10'd129;
    cyc(1);
    check("corner_addr", 32'(rom_address), 3839);
    check("corner_on", 32'(sprite_on), 1);
    draw_x = 10'd148;
    cyc(1);
    check("right_on", 32'(sprite_on), 0);
    draw_x = 10'd147; draw_y = 10'd130;
    cyc(1);
    check("below_on", 32'(sprite_on), 0);
    draw_x = 10'd100; draw_y = 10'd50;
    cyc(1);

    // idle loop
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_st($sformatf("idle%0d", k), 0, (k / 6) % 4);
    end
    draw_x = 10'd110; draw_y = 10'd60;
    cyc(1);
    check("addr_f1", 32'(rom_address), FSZ + 490);
    draw_x = 10'd100; draw_y = 10'd50;
    cyc(1);

    // punch, with ignored re-trigger
    do_reset();
    punch();
    tick();
    chk_st("p0", 1, 0);
    punch();
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 23) chk_st("p23", 1, 3);
      if (k == 6)  chk_st("p6", 1, 1);
    end
    chk_st("p24", 0, 0);
    tick();
    chk_st("p25", 0, 0);

    // hit during punch frame 2, restart during hit
    do_reset();
    punch();
    tick();
    ticks(12);
    chk_st("ph12", 1, 2);
    hit();
    tick();
    chk_st("h0", 2, 0);
    ticks(6);
    chk_st("h6", 2, 1);
    hit();
    tick();
    chk_st("hr0", 2, 0);
    ticks(11);
    chk_st("hr11", 2, 1);
    tick();
    chk_st("hr12", 0, 0);

    // punch + hit on the tick itself
    do_reset();
    @(negedge vga_clk);
    punch_req  = 1'b1;
    hit_req    = 1'b1;
    frame_tick = 1'b1;
    @(negedge vga_clk);
    punch_req  = 1'b0;
    hit_req    = 1'b0;
    frame_tick = 1'b0;
    cyc(1);
    chk_st("same0", 2, 0);
    ticks(12);
    chk_st("same12", 0, 0);
    tick();
    chk_st("same13", 0, 0);

    // reset during hit frame 1
    hit();
    tick();
    ticks(6);
    chk_st("rh", 2, 1);
    do_reset();
    check("rh_anim", 32'(anim_sel), 0);
    check("rh_busy", 32'(busy), 0);
    check("rh_on", 32'(sprite_on), 0);
    check("rh_addr", 32'(rom_address), 0);
    ticks(5);
    chk_st("rh5", 0, 0);
    tick();
    chk_st("rh6", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fighter_anim_ctrl.md
Name: fighter_anim_ctrl

Overview:
Per-fighter animation sequencer and sprite address generator feeding the per-animation sprite ROM/palette blocks (stand, punch, hit).
- Runs a state machine that selects the animation (IDLE, PUNCH, HIT) and steps frames on vertical-blank ticks.
- For every pixel, computes the ROM address and the sprite-coverage flag from draw_x/draw_y, the fighter position and the facing direction.
- Sits between game logic (requests, position) and the sprite ROM mux in the colour mapper.

Parameters:
SPRITE_W, 48, sprite width in pixels
SPRITE_H, 80, sprite height in pixels
IDLE_FRAMES, 4, frames in stand loop (1..4)
PUNCH_FRAMES, 4, frames in punch animation (1..4)
HIT_FRAMES, 2, frames in hit-reaction animation (1..4)
HOLD_TICKS, 6, frame_ticks each animation frame is displayed (>=1)

Ports:
vga_clk  input  1  pixel clock; the only clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse, once per video frame (start of vblank)
punch_req  input  1  one-cycle punch request from game logic
hit_req  input  1  one-cycle "fighter was hit" request
pos_x  input  10  sprite top-left X in screen pixels
pos_y  input  10  sprite top-left Y in screen pixels
facing_left  input  1  1 = mirror sprite horizontally
draw_x  input  10  current pixel X from the VGA controller
draw_y  input  10  current pixel Y from the VGA controller
rom_address  output  14  address into the selected animation ROM
anim_sel  output  2  0 = IDLE ROM, 1 = PUNCH ROM, 2 = HIT ROM
sprite_on  output  1  current pixel lies inside the sprite box
busy  output  1  1 while in PUNCH or HIT

Behaviour:
- Decided interface: one clock, vga_clk. Reset is synchronous and active-high. Nothing else is asynchronous.
- Reset values: state IDLE, frame 0, hold 0, pending flags 0, rom_address 0, anim_sel 0, sprite_on 0, busy 0. Reset mid-animation aborts immediately.

Request latching:
- hit_req sets pending_hit in any state.
- punch_req sets pending_punch only in IDLE. It is discarded in PUNCH and HIT.
- A request arriving in the same cycle as frame_tick is acted on at that tick.
- Both pending flags clear on every frame_tick.

State and frame updates happen only on frame_tick, in this priority:
1. pending_hit: go to HIT, frame 0, hold 0. This applies from any state, including HIT (restart). A pending punch is dropped.
2. IDLE with pending_punch: go to PUNCH, frame 0, hold 0.
3. Otherwise, if hold < HOLD_TICKS-1: hold++.
4. Otherwise hold = 0 and the frame advances:
   - IDLE wraps to frame 0 after IDLE_FRAMES-1.
   - PUNCH and HIT return to IDLE frame 0 after their last frame.

Outputs of the state machine:
- anim_sel and busy are registered and follow the state with one cycle of delay from the frame_tick edge.

Address path (registered, latency 1 vga_clk from draw_x/draw_y):
- rel_x = draw_x - pos_x and rel_y = draw_y - pos_y, computed as 10-bit unsigned with wrap.
- Inside means rel_x < SPRITE_W and rel_y < SPRITE_H. A negative difference wraps large and is therefore outside.
- col = facing_left ? SPRITE_W-1-rel_x : rel_x.
- Inside: rom_address = frame*SPRITE_W*SPRITE_H + rel_y*SPRITE_W + col, truncated to 14 bits (parameters keep this < 16384), and sprite_on = 1.
- Outside: rom_address = 0 and sprite_on = 0.
- The address uses the frame value registered before the current cycle. A frame change mid-scanline is permitted; game logic issues ticks in vblank.
- Multiplies by constants only; no runtime divider.

Test Plan:
- Reset, then 30 frame_ticks with no requests -> anim_sel = 0; frame sequence 0,0,0,0,0,0,1,… with a frame step every 6 ticks, wrapping 3 -> 0 at tick 24; busy = 0 throughout.
- pos = (100,50), draw = (110,60), facing_left = 0, frame 0 -> one cycle later rom_address = 490, sprite_on = 1. With facing_left = 1 -> rom_address = 517. draw = (99,60) -> sprite_on = 0, rom_address = 0.
- punch_req, then frame_tick -> anim_sel = 1, busy = 1. After 4*6 = 24 further ticks -> anim_sel = 0, busy = 0. A second punch_req during PUNCH is ignored (no re-trigger).
- hit_req during PUNCH frame 2, then tick -> anim_sel = 2, frame 0. hit_req during HIT frame 1 -> restarts at frame 0. 12 ticks after the last hit -> IDLE.
- punch_req and hit_req in the same cycle as frame_tick -> HIT entered at that tick; punch dropped; after HIT ends the state is IDLE, not PUNCH.
- reset asserted for one cycle during HIT frame 1 -> next cycle anim_sel = 0, busy = 0, sprite_on = 0, rom_address = 0; following tick continues IDLE hold counting from 0.
